// File: rtl/fetch_sequencer_if.sv
// Instruction memory port shared by the program loader and the fetch path.
// The sequencer drives address/write side; the memory returns read data combinationally.
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: arbitrates the instruction memory between the boot
// loader (LOAD) and the fetch path (RUN), with stall, branch redirect, halt and restart.
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_PC   = 0,
    parameter int PC_LIMIT   = 1023
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  load_ready,
    fetch_sequencer_if.master     imem,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt_req,
    input  logic                  restart,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [15:0]           fetch_count,
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_START = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_LAST  = ADDR_WIDTH'(PC_LIMIT);

    state_t                state_q, state_nx;
    logic [ADDR_WIDTH-1:0] pc_q, pc_nx;
    logic [DATA_WIDTH-1:0] instr_q, instr_nx;
    logic                  valid_q, valid_nx;
    logic [ADDR_WIDTH-1:0] pcout_q, pcout_nx;
    logic [15:0]           count_q, count_nx;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOAD;
            pc_q    <= PC_START;
            instr_q <= '0;
            valid_q <= 1'b0;
            pcout_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_nx;
            pc_q    <= pc_nx;
            instr_q <= instr_nx;
            valid_q <= valid_nx;
            pcout_q <= pcout_nx;
            count_q <= count_nx;
        end
    end

    always_comb begin
        state_nx       = state_q;
        pc_nx          = pc_q;
        instr_nx       = instr_q;
        valid_nx       = valid_q;
        pcout_nx       = pcout_q;
        count_nx       = count_q;
        load_ready     = 1'b0;
        imem.mem_addr  = pc_q;
        imem.mem_we    = 1'b0;
        imem.mem_wdata = '0;

        case (state_q)
            LOAD: begin
                // A write in the load_done cycle still lands before leaving LOAD.
                load_ready     = 1'b1;
                imem.mem_addr  = load_addr;
                imem.mem_wdata = load_data;
                imem.mem_we    = load_valid;
                if (load_done) begin
                    state_nx = RUN;
                    pc_nx    = PC_START;
                    valid_nx = 1'b0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_nx = HALT;
                    valid_nx = 1'b0;
                end else if (branch_taken) begin
                    pc_nx    = branch_target;
                    valid_nx = 1'b0;
                end else if (!stall) begin
                    instr_nx = imem.mem_rdata;
                    pcout_nx = pc_q;
                    valid_nx = 1'b1;
                    count_nx = (count_q == '1) ? count_q : count_q + 16'd1;
                    // >= so an out-of-range branch target also wraps on its next step.
                    pc_nx    = (pc_q >= PC_LAST) ? PC_START : pc_q + 1'b1;
                end
            end
            HALT: begin
                valid_nx = 1'b0;
                if (restart) begin
                    state_nx = LOAD;
                    pc_nx    = PC_START;
                end
            end
            default: begin
                state_nx = LOAD;
                pc_nx    = PC_START;
                valid_nx = 1'b0;
            end
        endcase
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pcout_q;
    assign fetch_count = count_q;
    assign state_out   = state_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the processor's instruction memory port and arbitrates it between two users: a boot loader that writes the program, and the fetch path that reads it.
- Holds the program counter, registers the fetched instruction for decode, and handles stall, branch redirect, halt and restart.
- Sits between the external program loader, the instruction memory (write-capable, combinational read) and the decode stage.

Parameters:
- ADDR_WIDTH, 10, width of the instruction address and PC.
- DATA_WIDTH, 32, width of an instruction word.
- RESET_PC, 0, PC value after reset, after load completion and after PC wrap.
- PC_LIMIT, 1023, last valid instruction address; incrementing past it wraps to RESET_PC.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- load_valid  input  1  loader presents a word this cycle.
- load_addr  input  ADDR_WIDTH  loader write address.
- load_data  input  DATA_WIDTH  loader write data.
- load_done  input  1  one-cycle pulse: program fully written.
- load_ready  output  1  high while the block is in LOAD and accepts words.
- mem_addr  output  ADDR_WIDTH  instruction memory address.
- mem_we  output  1  instruction memory write enable.
- mem_wdata  output  DATA_WIDTH  instruction memory write data.
- mem_rdata  input  DATA_WIDTH  instruction memory read data, combinational from mem_addr.
- stall  input  1  decode cannot accept; hold the fetch.
- branch_taken  input  1  redirect the fetch this cycle.
- branch_target  input  ADDR_WIDTH  redirect address.
- halt_req  input  1  stop fetching.
- restart  input  1  leave HALT and re-enter LOAD.
- instr_out  output  DATA_WIDTH  registered fetched instruction.
- instr_valid  output  1  instr_out is valid for decode.
- pc_out  output  ADDR_WIDTH  address of instr_out.
- fetch_count  output  16  number of instructions delivered; saturates at 16'hFFFF.
- state_out  output  2  encoding: LOAD=0, RUN=1, HALT=2.

Behaviour:
- Reset (resetn low, asynchronous; also takes effect mid-operation):
  - state=LOAD, pc=RESET_PC.
  - instr_out=0, instr_valid=0, pc_out=0, fetch_count=0.
  - Outputs derived from state follow immediately: load_ready=1, mem_we=0.
- Memory port mux (combinational):
  - LOAD: mem_addr=load_addr, mem_wdata=load_data, mem_we=load_valid.
  - RUN and HALT: mem_addr=pc, mem_we=0, mem_wdata=0.
- LOAD state:
  - Each load_valid cycle writes one word. Writes are unrestricted in order and address; a repeated address is overwritten.
  - load_done moves the block to RUN with pc=RESET_PC and instr_valid=0.
  - load_valid and load_done in the same cycle: the write is still performed, then the block moves to RUN.
  - stall, branch_taken and halt_req are ignored.
- RUN state, priority order per cycle is halt_req > branch_taken > stall > normal fetch:
  - halt_req: go to HALT, instr_valid<=0, pc held.
  - branch_taken: pc<=branch_target, instr_valid<=0 (one-bubble flush), instr_out held. Applies even while stall is high.
  - stall: pc, instr_out, pc_out, instr_valid and fetch_count all held.
  - Normal fetch: instr_out<=mem_rdata, pc_out<=pc, instr_valid<=1, fetch_count<=fetch_count+1 (saturating), pc<=pc+1.
  - PC wrap: if pc==PC_LIMIT, the next pc is RESET_PC.
  - Latency: an instruction is visible on instr_out one cycle after its pc is driven on mem_addr; throughput is one instruction per cycle.
  - load_valid and load_done are ignored; mem_we stays 0.
- HALT state:
  - instr_valid=0; pc, pc_out, instr_out and fetch_count held.
  - restart goes to LOAD with pc=RESET_PC; fetch_count is kept.
  - All other inputs are ignored.
- branch_target beyond PC_LIMIT is used unchanged; the next increment wraps it to RESET_PC.
- Unused encoding state_out=3 is unreachable; if it is ever entered, the block goes to LOAD on the next clock.

Test Plan:
- Reset, then load words 0x58200000@0, 0x58400000@1, 0x28220005@2, then load_done → state_out=1. The following cycles deliver instr_out=0x58200000/pc_out=0, then 0x58400000/1, then 0x28220005/2, with instr_valid=1 each cycle and fetch_count=3.
- load_valid with load_done in the same cycle (addr 7, data 0xDEADBEEF) → word written (mem_we=1 that cycle), state RUN next cycle, pc=0.
- Branch in RUN at pc=2, branch_taken=1 with branch_target=5 → next cycle instr_valid=0; the cycle after, pc_out=5 and instr_out=mem[5]. Repeat with stall=1 held → branch still taken.
- stall high for 3 cycles at pc=4 → instr_out, pc_out and fetch_count unchanged for 3 cycles, mem_addr=4 throughout; fetching resumes at pc 4 after release.
- PC_LIMIT=3: run from pc 0 with no stall → pc_out sequence 0,1,2,3,0,1.
- halt_req at pc=6 → instr_valid=0 and pc held for 5 cycles; restart → state_out=0, load_ready=1. Assert resetn low mid-RUN → all outputs at reset values immediately, without waiting for a clock.
